uart_tx_fifo: RTL and testbench

//   Byte FIFO directly upstream of the UART transmitter. Buffers bytes from a host/bus

---
 rtl/uart_tx_fifo.sv | 105 ++++++++++
 tb/tb_uart_tx_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter.
// The level and all status flags are registered, so ready/valid never depend combinationally on the opposite handshake.
module uart_tx_fifo #(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic [7:0]    s_data_i,
    input  logic          s_vld_i,
    output logic          s_rdy_o,
    output logic [7:0]    m_data_o,
    output logic          m_vld_o,
    input  logic          m_rdy_i,
    output logic [AW:0]   level_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          almost_full_o,
    output logic          almost_empty_o
);

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_L    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   AE_L    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic [AW:0]   level_nxt_s;
    logic          empty_r;
    logic          full_r;
    logic          af_r;
    logic          ae_r;
    logic          push_s;
    logic          pop_s;

    // Handshakes qualified by registered flags; next level with flush taking priority.
    always_comb begin
        push_s      = s_vld_i & ~full_r;
        pop_s       = m_rdy_i & ~empty_r;
        level_nxt_s = level_r;
        if (flush_i) begin
            level_nxt_s = {(AW+1){1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   level_nxt_s = level_r + LVL_ONE;
                2'b01:   level_nxt_s = level_r - LVL_ONE;
                default: level_nxt_s = level_r;
            endcase
        end
    end

    // Pointers, level and flags, all updated on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            af_r     <= 1'b0;
            ae_r     <= 1'b1;
        end else begin
            if (flush_i) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
            end
            level_r <= level_nxt_s;
            empty_r <= (level_nxt_s == {(AW+1){1'b0}});
            full_r  <= (level_nxt_s == DEPTH_L);
            af_r    <= (level_nxt_s >= AF_L);
            ae_r    <= (level_nxt_s <= AE_L);
        end
    end

    // Storage is deliberately left unreset; a flushed push is never written.
    always_ff @(posedge clk_i) begin
        if (push_s && !flush_i) begin
            mem_r[wr_ptr_r] <= s_data_i;
        end
    end

    assign m_data_o       = mem_r[rd_ptr_r];
    assign m_vld_o        = ~empty_r;
    assign s_rdy_o        = ~full_r;
    assign level_o        = level_r;
    assign empty_o        = empty_r;
    assign full_o         = full_r;
    assign almost_full_o  = af_r;
    assign almost_empty_o = ae_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a queue-based reference model is updated by a
// negedge monitor that also compares every DUT output against it.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_vld = 1'b0;
    logic       s_rdy;
    logic [7:0] m_data;
    logic       m_vld;
    logic       m_rdy = 1'b0;
    logic [4:0] level;
    logic       empty, full, afull, aempty;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 0;          // 0: never ready, 1: always, 2: random 50%
    logic [7:0] model_q[$];
    logic [7:0] popped_q[$];

    uart_tx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .s_data_i(s_data), .s_vld_i(s_vld), .s_rdy_o(s_rdy),
        .m_data_o(m_data), .m_vld_o(m_vld), .m_rdy_i(m_rdy),
        .level_o(level), .empty_o(empty), .full_o(full),
        .almost_full_o(afull), .almost_empty_o(aempty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: compare against the model, then apply this cycle's handshakes to it.
    initial begin
        forever begin
            @(negedge clk);
            chk("level", int'(level), model_q.size());
            chk("empty", int'(empty), int'(model_q.size() == 0));
            chk("full", int'(full), int'(model_q.size() == DEPTH));
            chk("almost_full", int'(afull), int'(model_q.size() >= AF));
            chk("almost_empty", int'(aempty), int'(model_q.size() <= AE));
            chk("s_rdy", int'(s_rdy), int'(model_q.size() < DEPTH));
            chk("m_vld", int'(m_vld), int'(model_q.size() > 0));
            if (model_q.size() > 0) chk("m_data", int'(m_data), int'(model_q[0]));
            if (rst || flush) begin
                model_q.delete();
            end else begin
                automatic bit do_pop  = m_rdy && (model_q.size() > 0);
                automatic bit do_push = s_vld && (model_q.size() < DEPTH);
                if (do_pop) popped_q.push_back(model_q.pop_front());
                if (do_push) model_q.push_back(s_data);
            end
        end
    end

    // Downstream ready pattern, changed just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_rdy = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : (rdy_mode == 1);
        end
    end

    // Offer one byte and hold it until the FIFO takes it (bounded).
    task automatic send(input logic [7:0] d);
        automatic bit taken = 1'b0;
        automatic int n = 0;
        s_vld  = 1'b1;
        s_data = d;
        while (!taken && n < 200) begin
            @(posedge clk);
            taken = s_rdy;
            #1;
            n++;
        end
        if (!taken) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        automatic int n = 0;
        s_vld = 1'b0;
        rdy_mode = 1;
        while (!empty && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain_empty", int'(empty), 1);
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("reset_level", int'(level), 0);
        chk("reset_s_rdy", int'(s_rdy), 1);
        chk("reset_m_vld", int'(m_vld), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ordering and pointer wrap with random back-pressure
        popped_q.delete();
        rdy_mode = 2;
        for (int i = 0; i < 48; i++) send(8'(i));
        drain();
        chk("order_count", popped_q.size(), 48);
        for (int i = 0; i < popped_q.size() && i < 48; i++) chk("order_byte", int'(popped_q[i]), i);

        // Fill to full, 17th byte held at the source
        rdy_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) send(8'hA0 + 8'(i));
        s_vld  = 1'b1;
        s_data = 8'hB0;
        repeat (3) @(posedge clk);
        #1;
        chk("full_level", int'(level), DEPTH);
        chk("full_flag", int'(full), 1);
        chk("full_s_rdy", int'(s_rdy), 0);

        // Simultaneous push/pop at the full boundary
        popped_q.delete();
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) send(8'hB0 + 8'(i));
        s_vld = 1'b0;
        chk("simul_first_pop", int'(popped_q.size() > 0 ? popped_q[0] : 8'h00), 8'hA0);
        drain();

        // Flush with a concurrent push
        rdy_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
        s_vld  = 1'b1;
        s_data = 8'hEE;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        s_vld = 1'b0;
        chk("flush_level", int'(level), 0);
        chk("flush_m_vld", int'(m_vld), 0);
        popped_q.delete();
        send(8'h77);
        drain();
        chk("flush_after_count", popped_q.size(), 1);
        chk("flush_after_byte", int'(popped_q.size() > 0 ? popped_q[0] : 8'h00), 8'h77);

        // First-word-fall-through latency
        rdy_mode = 0;
        @(posedge clk);
        #1;
        s_vld  = 1'b1;
        s_data = 8'h55;
        @(posedge clk);
        #1;
        s_vld = 1'b0;
        chk("latency_m_vld", int'(m_vld), 1);
        chk("latency_m_data", int'(m_data), 8'h55);
        drain();

        // Random mixed traffic
        rdy_mode = 2;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(3, 0) != 0) send(8'($urandom));
            else begin
                s_vld = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
